// File: rtl/pdm_mic_decimator.sv
// rtl/pdm_mic_decimator.sv - PDM microphone clock generator and order-2 CIC decimator to 16-bit PCM
module pdm_mic_decimator #(
  parameter int CLK_DIV = 32,
  parameter int DECIM   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pdm_in,
  output logic               mic_clk,
  output logic signed [15:0] pcm_out,
  output logic               pcm_valid,
  output logic               clipped
);

  localparam int LOG2D = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int W     = 2 * LOG2D + 2;
  localparam int SHIFT = 15 - 2 * LOG2D;
  localparam int DW    = $clog2(CLK_DIV);

  logic [DW-1:0]      div_cnt;
  logic [DW-1:0]      div_next;
  logic               bit_strobe;
  logic               sync_1;
  logic               sync_s;
  logic [LOG2D-1:0]   bit_cnt;
  logic               decim_tick;
  logic signed [W-1:0] x;
  logic signed [W-1:0] i1, i2, d1, d2;
  logic signed [W-1:0] c1, c2;
  logic signed [16:0] scaled;
  logic signed [15:0] sat_val;
  logic               sat_hit;

  assign div_next   = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
  assign bit_strobe = (div_cnt == DW'(CLK_DIV - 1));
  assign x          = sync_s ? W'(1) : {W{1'b1}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      mic_clk <= 1'b0;
      sync_1  <= 1'b0;
      sync_s  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      mic_clk <= (div_next < DW'(CLK_DIV / 2));
      sync_1  <= pdm_in;
      sync_s  <= sync_1;
    end
  end

  // Integrators wrap freely; the comb differences recover the exact block sums.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i1         <= '0;
      i2         <= '0;
      bit_cnt    <= '0;
      decim_tick <= 1'b0;
    end else begin
      decim_tick <= bit_strobe && (bit_cnt == LOG2D'(DECIM - 1));
      if (bit_strobe) begin
        i1      <= i1 + x;
        i2      <= i2 + i1;
        bit_cnt <= bit_cnt + LOG2D'(1);
      end
    end
  end

  assign c1     = i2 - d1;
  assign c2     = c1 - d2;
  assign scaled = 17'(c2) <<< SHIFT;

  always_comb begin
    sat_val = scaled[15:0];
    sat_hit = 1'b0;
    if (scaled > 17'sd32767) begin
      sat_val = 16'sh7fff;
      sat_hit = 1'b1;
    end else if (scaled < -17'sd32768) begin
      sat_val = -16'sh8000;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d1        <= '0;
      d2        <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      clipped   <= 1'b0;
    end else begin
      pcm_valid <= decim_tick;
      clipped   <= decim_tick && sat_hit;
      if (decim_tick) begin
        d1      <= i2;
        d2      <= c1;
        pcm_out <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// tb/tb_pdm_mic_decimator.sv - directed bench for pdm_mic_decimator
module tb_pdm_mic_decimator;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               pdm_in = 1'b0;
  logic               mic_clk;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;
  logic               clipped;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] pat = 4'h0;
  bit         toggle_in_reset = 1'b0;
  int         idx = 0;
  logic       mic_prev = 1'b0;

  pdm_mic_decimator #(.CLK_DIV(32), .DECIM(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .mic_clk   (mic_clk),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .clipped   (clipped)
  );

  always #5 clk = ~clk;

  // One new PDM bit per mic_clk period, changed just after its rising edge.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      idx    = 0;
      pdm_in = toggle_in_reset ? ~pdm_in : pat[0];
    end else if (mic_clk && !mic_prev) begin
      pdm_in = pat[idx[1:0]];
      idx++;
    end
    mic_prev = mic_clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic start_run(input logic [3:0] p);
    pat = p;
    toggle_in_reset = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(output int n, output int mid_pcm, output int v1);
    n = 0;
    mid_pcm = 0;
    v1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) v1 = int'(pcm_valid);
      if (n == 1000) mid_pcm = int'(pcm_out);
    end while (!pcm_valid && n < 3000);
  endtask

  task automatic run_case(input string name, input logic [3:0] p,
                          input int e0, input int c0, input int e1, input int c1,
                          input int es, input int cs, input bit chk_early);
    int n, mid, v1, prev;
    start_run(p);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(n, mid, v1);
      check({name, "_latency"}, n, (i == 0) ? 2049 : 2048);
      check({name, "_hold"}, mid, prev);
      if (i > 0) check({name, "_one_cycle"}, v1, 0);
      if (i >= 2) begin
        check({name, "_pcm"}, int'(pcm_out), es);
        check({name, "_clip"}, int'(clipped), cs);
      end else if (chk_early) begin
        check({name, "_pcm_early"}, int'(pcm_out), (i == 0) ? e0 : e1);
        check({name, "_clip_early"}, int'(clipped), (i == 0) ? c0 : c1);
      end
      prev = int'(pcm_out);
    end
  endtask

  initial begin
    int n, mid, v1;

    toggle_in_reset = 1'b1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("reset_outputs", int'({mic_clk, pcm_valid, clipped, pcm_out}), 0);
    end

    toggle_in_reset = 1'b0;
    rst = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check("mic_clk", int'(mic_clk), ((k % 32) < 16) ? 1 : 0);
    end

    run_case("ones",  4'b1111,  16128, 0,  32767, 1,  32767, 1, 1'b1);
    run_case("zeros", 4'b0000, -16128, 0, -32768, 0, -32768, 0, 1'b1);
    run_case("alt",   4'b0101,      0, 0,      0, 0,      0, 0, 1'b0);
    run_case("dens75", 4'b0111,     0, 0,      0, 0,  16384, 0, 1'b0);

    start_run(4'b0000);
    repeat (30 * 32) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n, mid, v1);
      check("midrst_latency", n, (i == 0) ? 2049 : 2048);
      check("midrst_pcm", int'(pcm_out), (i == 0) ? -16128 : -32768);
      check("midrst_clip", int'(clipped), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
